// File: rtl/kpn_channel_fifo.sv
// Buffered 16-bit KPN token channel: valid/ready FIFO with first-word-fall-through
// read side and a sticky peak-occupancy monitor for channel sizing.
module kpn_channel_fifo #(
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [15:0]           entry_1,
    input  logic                  entry_valid,
    output logic                  entry_ready,
    output logic [15:0]           output_1,
    output logic                  output_valid,
    input  logic                  output_ready,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   max_count
);

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

    logic [15:0]           mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  wr_en, rd_en;

    // Flags come only from registered count, so ready never depends on output_ready.
    assign entry_ready  = (count != FULL_CNT);
    assign output_valid = (count != '0);
    assign wr_en        = entry_valid && entry_ready;
    assign rd_en        = output_valid && output_ready;

    // Mask the stale array word while empty so the head reads 0 after reset/drain.
    assign output_1 = output_valid ? mem[rd_ptr] : 16'h0000;

    always_comb begin
        count_next = count;
        if (wr_en && !rd_en)
            count_next = count + (ADDR_WIDTH+1)'(1);
        else if (rd_en && !wr_en)
            count_next = count - (ADDR_WIDTH+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= entry_1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            max_count <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            count <= count_next;
            if (count_next > max_count)
                max_count <= count_next;
        end
    end

endmodule
